// File: rtl/scroll_scan_feeder.sv
// Scrolling message feeder for a time-multiplexed character display.
// A circular message buffer is shown through a DIGITS-wide window whose start
// index moves by button step or auto-scroll tick. The window start is latched
// once per scan frame so a scroll never tears a frame half-way through.
module scroll_scan_feeder #(
  parameter int DIGITS    = 4,
  parameter int DEPTH     = 8,
  parameter int CHAR_W    = 4,
  parameter int SLOT_LOG2 = 2,
  parameter int TICK_W    = 22
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     step_in,
  input  logic                     auto_en,
  input  logic                     dir,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [CHAR_W-1:0]        wr_data,
  output logic [CHAR_W-1:0]        char_out,
  output logic [DIGITS-1:0]        an_n,
  output logic [$clog2(DEPTH)-1:0] scroll_pos
);

  localparam int AW = $clog2(DEPTH);
  localparam int KW = $clog2(DIGITS);
  localparam int CW = KW + SLOT_LOG2;
  // Load happens at the first phase of a slot; the anode is lit only in the
  // second-to-last phase so the char has settled and the slot edges stay dark.
  localparam logic [SLOT_LOG2-1:0] PH_LOAD = '0;
  localparam logic [SLOT_LOG2-1:0] PH_ON   = SLOT_LOG2'((1 << SLOT_LOG2) - 2);

  logic [CW-1:0]     r_scan;
  logic [AW-1:0]     r_frame;
  logic [AW-1:0]     r_pos;
  logic [CHAR_W-1:0] r_char;
  logic [DIGITS-1:0] r_an;
  logic [CHAR_W-1:0] r_mem [DEPTH];
  logic [TICK_W-1:0] r_div;
  // [0],[1]: two-flop synchroniser; [2]: previous synchronised level
  logic [2:0]        r_sync;

  logic [KW-1:0]        w_slot;
  logic [SLOT_LOG2-1:0] w_phase;
  logic [AW-1:0]        w_frame_eff;
  logic [AW-1:0]        w_rd_addr;
  logic [KW-1:0]        w_an_idx;
  logic                 w_step;
  logic                 w_tick;
  logic                 w_event;

  assign w_slot      = r_scan[CW-1:SLOT_LOG2];
  assign w_phase     = r_scan[SLOT_LOG2-1:0];
  // At scan 0 the frame register is being loaded this cycle, so bypass it
  assign w_frame_eff = (r_scan == '0) ? r_pos : r_frame;
  assign w_rd_addr   = w_frame_eff + AW'(w_slot);
  // Slot 0 drives the leftmost digit, i.e. the top anode bit
  assign w_an_idx    = KW'(DIGITS - 1) - w_slot;
  assign w_step      = r_sync[1] & ~r_sync[2];
  assign w_tick      = (&r_div) & auto_en;
  assign w_event     = w_step | w_tick;

  // Scan counter and once-per-frame latch of the window start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan  <= '0;
      r_frame <= '0;
    end else begin
      r_scan <= r_scan + CW'(1);
      if (r_scan == '0) r_frame <= r_pos;
    end
  end

  // Registered char load and anode strobe for the slot being scanned
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_char <= '0;
      r_an   <= '1;
    end else begin
      if (w_phase == PH_LOAD) r_char <= r_mem[w_rd_addr];
      if (w_phase == PH_ON) r_an <= ~(DIGITS'(1) << w_an_idx);
      else                  r_an <= '1;
    end
  end

  // Message buffer; reset restores the index pattern 0,1,2,...
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= CHAR_W'(i);
    end else if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Button synchroniser and rising-edge history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[1:0], step_in};
  end

  // Auto-scroll divider, parked at zero whenever auto-scroll is off
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_div <= '0;
    else if (!auto_en) r_div <= '0;
    else              r_div <= r_div + TICK_W'(1);
  end

  // Window start; step and tick in the same cycle merge into one move
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pos <= '0;
    end else if (w_event) begin
      if (dir) r_pos <= r_pos - AW'(1);
      else     r_pos <= r_pos + AW'(1);
    end
  end

  assign char_out   = r_char;
  assign an_n       = r_an;
  assign scroll_pos = r_pos;

endmodule

// File: tb/tb_scroll_scan_feeder.sv
// Bench for scroll_scan_feeder (DIGITS=4, DEPTH=8, CHAR_W=4, SLOT_LOG2=2,
// TICK_W=4). A cycle-level reference model built from the display rules runs
// alongside the DUT; scenario tasks compare against it and against constants.
module tb_scroll_scan_feeder;
  logic       clk = 1'b0, reset = 1'b0, step_in = 1'b0, auto_en = 1'b0;
  logic       dir = 1'b0, wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [3:0] char_out, an_n;
  logic [2:0] scroll_pos;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  scroll_scan_feeder #(.DIGITS(4), .DEPTH(8), .CHAR_W(4), .SLOT_LOG2(2), .TICK_W(4)) dut (
    .clk(clk), .reset(reset), .step_in(step_in), .auto_en(auto_en), .dir(dir),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .char_out(char_out), .an_n(an_n), .scroll_pos(scroll_pos)
  );

  // Reference model: frame of 16 cycles, 4 slots of 4 cycles each
  logic [3:0] m_mem [8];
  int         m_pos, m_frame, mc, m_acnt;
  logic [3:0] m_char, m_an;
  logic [2:0] m_hist;   // step_in samples, [0] newest

  always @(posedge clk or posedge reset) begin
    int c, k, fe, na;
    bit ev;
    if (reset) begin
      for (int i = 0; i < 8; i++) m_mem[i] <= 4'(i);
      m_pos <= 0; m_frame <= 0; mc <= 0; m_acnt <= 0;
      m_char <= 4'h0; m_an <= 4'hF; m_hist <= 3'b000;
    end else begin
      c  = mc % 16;
      k  = c / 4;
      fe = (c == 0) ? m_pos : m_frame;
      if (c == 0) m_frame <= m_pos;
      if (c % 4 == 0) m_char <= m_mem[(fe + k) % 8];
      m_an <= (c % 4 == 2) ? ~(4'b1000 >> k) : 4'hF;
      na = auto_en ? m_acnt + 1 : 0;
      m_acnt <= na;
      // step acts when the button was high two samples ago and low three ago
      ev = (auto_en && (na % 16 == 0)) || (m_hist[1] && !m_hist[2]);
      m_hist <= {m_hist[1:0], step_in};
      if (ev) m_pos <= dir ? (m_pos + 7) % 8 : (m_pos + 1) % 8;
      if (wr_en) m_mem[wr_addr] <= wr_data;
      mc <= mc + 1;
    end
  end

  // Collect the chars of the next complete frame, slot 0 in the top nibble
  task automatic grab_frame(output logic [15:0] f);
    f = '0;
    while (mc % 16 != 0) @(negedge clk);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (j % 4 == 0) f[15 - 4*(j/4) -: 4] = char_out;
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_an;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({char_out, an_n, scroll_pos} !== {4'h0, 4'hF, 3'd0}) begin
      errors++;
      $display("FAIL reset_state: got char=%h an=%b pos=%0d want char=0 an=1111 pos=0", char_out, an_n, scroll_pos);
    end
    @(negedge clk); reset = 1'b0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      exp_an = (j % 4 == 2) ? ~(4'b1000 >> (j / 4)) : 4'hF;
      checks++;
      if (an_n !== exp_an || char_out !== 4'(j / 4)) begin
        errors++;
        $display("FAIL reset_scan cyc%0d: got char=%h an=%b want char=%h an=%b", j, char_out, an_n, 4'(j / 4), exp_an);
      end
    end
  endtask

  task automatic test_write_step();
    logic [3:0]  pat [8] = '{4'h1, 4'h4, 4'h3, 4'h5, 4'hA, 4'hB, 4'hC, 4'hD};
    logic [15:0] f;
    for (int a = 0; a < 8; a++) begin
      wr_en = 1'b1; wr_addr = 3'(a); wr_data = pat[a];
      @(negedge clk);
    end
    wr_en = 1'b0; dir = 1'b0;
    for (int s = 1; s <= 9; s++) begin
      step_in = 1'b1;
      for (int n = 0; n < 8; n++) begin
        if (n == 4) step_in = 1'b0;
        @(negedge clk);
        checks++;
        if ({char_out, an_n, scroll_pos} !== {m_char, m_an, 3'(m_pos)}) begin
          errors++;
          $display("FAIL step_model s%0d n%0d: got %h/%b/%0d want %h/%b/%0d", s, n, char_out, an_n, scroll_pos, m_char, m_an, m_pos);
        end
      end
      checks++;
      if (scroll_pos !== 3'(s % 8)) begin
        errors++;
        $display("FAIL step_pos s%0d: got %0d want %0d", s, scroll_pos, s % 8);
      end
      if (s == 6) begin
        grab_frame(f);
        checks++;
        if (f !== 16'hCD14) begin
          errors++;
          $display("FAIL frame_pos6: got %h want CD14", f);
        end
      end
    end
  endtask

  task automatic test_dir();
    logic [15:0] f;
    dir = 1'b1;
    for (int s = 0; s < 2; s++) begin
      step_in = 1'b1; repeat (4) @(negedge clk);
      step_in = 1'b0; repeat (4) @(negedge clk);
      checks++;
      if (scroll_pos !== 3'((8 - s) % 8)) begin
        errors++;
        $display("FAIL dir_pos s%0d: got %0d want %0d", s, scroll_pos, (8 - s) % 8);
      end
    end
    grab_frame(f);
    checks++;
    if (f !== 16'hD143) begin
      errors++;
      $display("FAIL frame_pos7: got %h want D143", f);
    end
    // step lands mid-frame: current frame keeps the old window
    while (mc % 16 != 0) @(negedge clk);
    step_in = 1'b1;
    grab_frame(f);
    step_in = 1'b0;
    checks++;
    if (f !== 16'hD143 || scroll_pos !== 3'd6) begin
      errors++;
      $display("FAIL midframe_hold: got frame=%h pos=%0d want D143 pos=6", f, scroll_pos);
    end
    grab_frame(f);
    checks++;
    if (f !== 16'hCD14) begin
      errors++;
      $display("FAIL midframe_next: got %h want CD14", f);
    end
  endtask

  task automatic test_auto();
    int p;
    dir = 1'b0;
    p = m_pos;
    auto_en = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      checks++;
      if (scroll_pos !== 3'((p + n / 16) % 8)) begin
        errors++;
        $display("FAIL auto_run n%0d: got %0d want %0d", n, scroll_pos, (p + n / 16) % 8);
      end
    end
    auto_en = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (scroll_pos !== 3'((p + 2) % 8)) begin
      errors++;
      $display("FAIL auto_off: got %0d want %0d", scroll_pos, (p + 2) % 8);
    end
    auto_en = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      checks++;
      if (scroll_pos !== 3'((p + 2 + n / 16) % 8)) begin
        errors++;
        $display("FAIL auto_restart n%0d: got %0d want %0d", n, scroll_pos, (p + 2 + n / 16) % 8);
      end
    end
    // step pulse timed to land on the same edge as the next tick
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      checks++;
      if (scroll_pos !== 3'((p + 3 + (n >= 16 ? 1 : 0)) % 8)) begin
        errors++;
        $display("FAIL auto_coincide n%0d: got %0d want %0d", n, scroll_pos, (p + 3 + (n >= 16 ? 1 : 0)) % 8);
      end
      if (n == 13) step_in = 1'b1;
    end
    step_in = 1'b0; auto_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write_collide();
    int          p;
    logic [3:0]  old_v, new_v;
    logic [15:0] f;
    while (mc % 16 != 0) @(negedge clk);
    p = m_pos; old_v = m_mem[p]; new_v = ~old_v;
    wr_en = 1'b1; wr_addr = 3'(p); wr_data = new_v;
    @(negedge clk);
    wr_en = 1'b0;
    checks++;
    if (char_out !== old_v) begin
      errors++;
      $display("FAIL collide_old: got %h want %h", char_out, old_v);
    end
    grab_frame(f);
    checks++;
    if (f[15:12] !== new_v) begin
      errors++;
      $display("FAIL collide_new: got %h want %h", f[15:12], new_v);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      checks++;
      if ({char_out, an_n, scroll_pos} !== {m_char, m_an, 3'(m_pos)}) begin
        errors++;
        $display("FAIL random n%0d: got %h/%b/%0d want %h/%b/%0d", n, char_out, an_n, scroll_pos, m_char, m_an, m_pos);
      end
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 3'($urandom);
      wr_data = 4'($urandom);
      if (n % 8 == 0)  step_in = 1'($urandom_range(0, 1));
      if (n % 40 == 0) dir     = 1'($urandom_range(0, 1));
      if (n % 60 == 0) auto_en = 1'($urandom_range(0, 1));
    end
    wr_en = 1'b0; step_in = 1'b0; auto_en = 1'b0; dir = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] f;
    int guard = 0;
    while (m_an === 4'hF && guard < 32) begin @(negedge clk); guard++; end
    checks++;
    if (an_n === 4'hF) begin
      errors++;
      $display("FAIL resetmid_setup: got an=%b want an anode low", an_n);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({char_out, an_n, scroll_pos} !== {4'h0, 4'hF, 3'd0}) begin
      errors++;
      $display("FAIL resetmid_async: got char=%h an=%b pos=%0d want 0/1111/0", char_out, an_n, scroll_pos);
    end
    #1 reset = 1'b0;
    grab_frame(f);
    checks++;
    if (f !== 16'h0123) begin
      errors++;
      $display("FAIL resetmid_mem: got %h want 0123", f);
    end
  endtask

  initial begin
    test_reset();
    test_write_step();
    test_dir();
    test_auto();
    test_write_collide();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
